// File: rtl/fa_serial_add_ctrl.sv
// Bit-serial adder sequencer: one full adder reused once per bit, valid/ready on both sides.
// Optional signed-overflow output enabled by defining FA_SERIAL_OVF_EN.
module fa_serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef FA_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH:0]   sum_ext;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             fa_sum, fa_carry, last_bit;
`ifdef FA_SERIAL_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // The single full adder, fed the LSBs of the shift registers and the running carry.
  assign fa_sum   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign fa_carry = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
  assign last_bit = (cnt_q == CntW'(WIDTH - 1));
  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at sum[0].
  assign sum_ext  = {fa_sum, sum_q};

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef FA_SERIAL_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        sum_d   = sum_ext[WIDTH:1];
        carry_d = fa_carry;
        cnt_d   = cnt_q + CntW'(1);
        if (last_bit) begin
          cout_d  = fa_carry;
`ifdef FA_SERIAL_OVF_EN
          // Carry into the MSB differs from carry out of it.
          ovf_d   = carry_q ^ fa_carry;
`endif
          state_d = StDone;
        end
      end
      StDone: begin
        if (done_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef FA_SERIAL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef FA_SERIAL_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign start_ready = (state_q == StIdle);
  assign done_valid  = (state_q == StDone);
  assign busy        = (state_q != StIdle);
  assign sum         = sum_q;
  assign cout        = cout_q;
`ifdef FA_SERIAL_OVF_EN
  assign ovf         = ovf_q;
`endif

endmodule

// File: tb/tb_fa_serial_add_ctrl.sv
// Self-checking bench for fa_serial_add_ctrl: directed cases plus random streaming against an
// arithmetic reference model; a second WIDTH=1 instance covers the single-bit build.
module tb_fa_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start_valid, start_ready;
  logic [W-1:0] a, b, sum;
  logic         cin, cout, done_valid, done_ready, busy;
`ifdef FA_SERIAL_OVF_EN
  logic         ovf;
  logic         s1_ovf;
`endif

  logic         s1_start_valid, s1_start_ready;
  logic [0:0]   s1_a, s1_b, s1_sum;
  logic         s1_cin, s1_cout, s1_done_valid, s1_done_ready, s1_busy;

  int checks = 0;
  int errors = 0;

  fa_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .sum         (sum),
    .cout        (cout),
    .busy        (busy)
`ifdef FA_SERIAL_OVF_EN
    ,
    .ovf         (ovf)
`endif
  );

  fa_serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (s1_start_valid),
    .start_ready (s1_start_ready),
    .a           (s1_a),
    .b           (s1_b),
    .cin         (s1_cin),
    .done_valid  (s1_done_valid),
    .done_ready  (s1_done_ready),
    .sum         (s1_sum),
    .cout        (s1_cout),
    .busy        (s1_busy)
`ifdef FA_SERIAL_OVF_EN
    ,
    .ovf         (s1_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic for a+b+cin and signed range check for overflow.
  task automatic ref_add(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_cin,
                         output logic [W-1:0] r_sum, output logic r_cout, output logic r_ovf);
    int full, sa, sb, ss;
    full   = int'(op_a) + int'(op_b) + int'(op_cin);
    r_sum  = full[W-1:0];
    r_cout = full[W];
    sa     = (int'(op_a) >= 2 ** (W - 1)) ? int'(op_a) - 2 ** W : int'(op_a);
    sb     = (int'(op_b) >= 2 ** (W - 1)) ? int'(op_b) - 2 ** W : int'(op_b);
    ss     = sa + sb + int'(op_cin);
    r_ovf  = (ss > 2 ** (W - 1) - 1) || (ss < -(2 ** (W - 1)));
  endtask

  // Starts in IDLE at #1 after an edge; optionally holds DONE for 'hold' cycles with a stray start.
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_cin,
                        input int hold);
    logic [W-1:0] e_sum;
    logic         e_cout, e_ovf;
    int           cyc;
    ref_add(op_a, op_b, op_cin, e_sum, e_cout, e_ovf);
    check("idle_ready", start_ready, 1);
    a = op_a; b = op_b; cin = op_cin; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    a = ~op_a; b = ~op_b; cin = ~op_cin;
    check("run_busy", busy, 1);
    cyc = 0;
    while (!done_valid && cyc < W + 4) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, W);
    check("sum", sum, e_sum);
    check("cout", cout, e_cout);
`ifdef FA_SERIAL_OVF_EN
    check("ovf", ovf, e_ovf);
`endif
    check("done_start_ready", start_ready, 0);
    for (int i = 0; i < hold; i++) begin
      start_valid = (i == 1);
      @(posedge clk); #1;
      check("hold_valid", done_valid, 1);
      check("hold_sum", sum, e_sum);
      check("hold_cout", cout, e_cout);
      check("hold_start_ready", start_ready, 0);
    end
    start_valid = 1'b0;
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    check("release_valid", done_valid, 0);
    check("release_idle", start_ready, 1);
    check("release_busy", busy, 0);
  endtask

  initial begin
    logic [W-1:0] e_sum;
    logic         e_cout, e_ovf;
    logic [W:0]   exp_q[$];
    logic [W:0]   got_w;
    int           last_done, results;

    rst_n = 1'b0;
    start_valid = 1'b0; done_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    s1_start_valid = 1'b0; s1_done_ready = 1'b0; s1_a = '0; s1_b = '0; s1_cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_start_ready", start_ready, 1);
    check("rst_done_valid", done_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
`ifdef FA_SERIAL_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases, including backpressure with a stray start.
    run_op(8'h5A, 8'h3C, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 0);
    run_op(8'h00, 8'h00, 1'b1, 0);
    run_op(8'hA5, 8'h6E, 1'b1, 5);

    // Reset after the third RUN cycle aborts the add.
    a = 8'hC3; b = 8'h9A; cin = 1'b1; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_done_valid", done_valid, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    run_op(8'h7F, 8'h01, 1'b0, 0);

    // Streaming with both handshakes tied high: one result every W+2 cycles.
    last_done = -1;
    results = 0;
    start_valid = 1'b1;
    done_ready = 1'b1;
    for (int cyc = 0; cyc < 240; cyc++) begin
      if (done_valid) begin
        got_w = {cout, sum};
        if (exp_q.size() == 0) begin
          check("stream_unexpected", 1, 0);
        end else begin
          check("stream_result", got_w, exp_q.pop_front());
        end
        if (last_done >= 0) check("stream_interval", cyc - last_done, W + 2);
        last_done = cyc;
        results++;
      end
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      if (cyc >= 225) start_valid = 1'b0;
      if (start_ready && start_valid) begin
        ref_add(a, b, cin, e_sum, e_cout, e_ovf);
        exp_q.push_back({e_cout, e_sum});
      end
      @(posedge clk); #1;
    end
    check("stream_drained", exp_q.size(), 0);
    check("stream_count", results >= 20, 1);
    done_ready = 1'b0;
    start_valid = 1'b0;

    // Single-bit instance: 1 + 1 + 1.
    s1_a = 1'b1; s1_b = 1'b1; s1_cin = 1'b1; s1_start_valid = 1'b1;
    @(posedge clk); #1;
    s1_start_valid = 1'b0;
    check("w1_busy", s1_busy, 1);
    check("w1_not_yet", s1_done_valid, 0);
    @(posedge clk); #1;
    check("w1_done_valid", s1_done_valid, 1);
    check("w1_sum", s1_sum, 1);
    check("w1_cout", s1_cout, 1);
`ifdef FA_SERIAL_OVF_EN
    check("w1_ovf", s1_ovf, 0);
`endif
    s1_done_ready = 1'b1;
    @(posedge clk); #1;
    s1_done_ready = 1'b0;
    check("w1_release", s1_start_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
